// File: rtl/multi_block_dispatcher.sv
// -----------------------------------------------------------------------------
// multi_block_dispatcher
//
// Walks a VDIM-dimensional block grid (offset 0 .. end-1 in steps of `step`,
// last dimension fastest). Each block offset is handed to one of N_CORE
// downstream cores. Cores are picked round-robin, and a core is skipped while it
// already has MAX_OUT blocks outstanding. When every offset has been handed out
// and every core has reported its blocks finished, the job completes with a
// single-cycle done pulse.
//
// Ports
//   i_clk, i_rst     clock (rising edge) / asynchronous active-low reset
//   src_rdy/src_ack  job handshake; a job is taken when both are high
//   i_bgrid_step     per-dimension block step     (latched when a job is taken)
//   i_bgrid_end      per-dimension exclusive end  (latched when a job is taken)
//   bofs_rdy/ack     per-core offset handshake; at most one rdy bit is high
//   o_bofs           offset offered to the core whose bofs_rdy bit is high
//   blkdone_dval     per-core pulse, one per finished block
//   o_done_dval      single-cycle pulse when the whole job has completed
//   o_blk_cnt        number of blocks dispatched in the current or last job
// -----------------------------------------------------------------------------
package TauCfg;
    localparam int VDIM    = 2;
    localparam int WORK_BW = 8;
endpackage

module multi_block_dispatcher #(
    parameter int N_CORE  = 2,
    parameter int VDIM    = TauCfg::VDIM,
    parameter int WBW     = TauCfg::WORK_BW,
    parameter int MAX_OUT = 2,
    parameter int CNT_BW  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      src_rdy,
    output logic                      src_ack,
    input  logic [VDIM-1:0][WBW-1:0]  i_bgrid_step,
    input  logic [VDIM-1:0][WBW-1:0]  i_bgrid_end,
    output logic [N_CORE-1:0]         bofs_rdy,
    input  logic [N_CORE-1:0]         bofs_ack,
    output logic [VDIM-1:0][WBW-1:0]  o_bofs,
    input  logic [N_CORE-1:0]         blkdone_dval,
    output logic                      o_done_dval,
    output logic [CNT_BW-1:0]         o_blk_cnt
);

    localparam int CRED_BW = $clog2(MAX_OUT + 1);
    localparam int RR_BW   = (N_CORE > 1) ? $clog2(N_CORE) : 1;
    localparam logic [CRED_BW-1:0] CRED_MAX = CRED_BW'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t                           state, state_nxt;
    logic [VDIM-1:0][WBW-1:0]         step_q, end_q, ofs_nxt;
    logic [N_CORE-1:0][CRED_BW-1:0]   credit, credit_nxt;
    logic [RR_BW-1:0]                 rr, rr_nxt, sel, sel_nxt;
    logic [N_CORE-1:0]                ack_hit, rdy_nxt;
    logic [WBW:0]                     sum;
    logic                             carry, last_ofs, accept, adv, empty_grid, all_idle;

    assign src_ack = src_rdy && (state == IDLE);
    assign accept  = src_ack;
    // Only the core that is currently offered an offset may complete a handshake.
    assign ack_hit = bofs_rdy & bofs_ack;
    assign adv     = |ack_hit;

    always_comb begin
        empty_grid = 1'b0;
        for (int d = 0; d < VDIM; d++) begin
            if (i_bgrid_end[d] == '0) empty_grid = 1'b1;
        end
    end

    // Odometer-style increment: the sum is one bit wider so it cannot wrap
    // before being compared with the end bound. A zero step always wraps, so
    // that dimension contributes a single offset.
    always_comb begin
        ofs_nxt = o_bofs;
        carry   = 1'b1;
        sum     = '0;
        for (int d = VDIM - 1; d >= 0; d--) begin
            sum = {1'b0, o_bofs[d]} + {1'b0, step_q[d]};
            if (carry) begin
                if ((step_q[d] == '0) || (sum >= {1'b0, end_q[d]})) begin
                    ofs_nxt[d] = '0;
                end else begin
                    ofs_nxt[d] = sum[WBW-1:0];
                    carry      = 1'b0;
                end
            end
        end
        last_ofs = carry;
    end

    // An ack and a done on the same core in the same cycle cancel out. A done
    // pulse on a core with nothing outstanding is dropped.
    always_comb begin
        credit_nxt = credit;
        for (int k = 0; k < N_CORE; k++) begin
            unique case ({ack_hit[k], blkdone_dval[k] && (credit[k] != '0)})
                2'b10:   credit_nxt[k] = credit[k] + CRED_BW'(1);
                2'b01:   credit_nxt[k] = credit[k] - CRED_BW'(1);
                default: credit_nxt[k] = credit[k];
            endcase
        end
    end

    assign all_idle = (credit_nxt == '0);

    // A new core is picked only while no offer is outstanding. Because it uses
    // the post-update credits, a done pulse can re-open a core in the same cycle.
    always_comb begin
        int idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        sel_nxt = sel;
        rdy_nxt = '0;
        if (bofs_rdy != '0) begin
            rdy_nxt = adv ? '0 : bofs_rdy;
        end else if (state == DISPATCH) begin
            for (int i = 0; i < N_CORE; i++) begin
                idx = (int'(rr) + i) % N_CORE;
                if (!found && (credit_nxt[idx] < CRED_MAX)) begin
                    found        = 1'b1;
                    sel_nxt      = RR_BW'(idx);
                    rdy_nxt[idx] = 1'b1;
                end
            end
        end
    end

    assign rr_nxt = (sel == RR_BW'(N_CORE - 1)) ? '0 : sel + RR_BW'(1);

    // NOTE: next-state logic assigns its default first, so a path that does not
    // set state_nxt keeps the current state instead of inferring a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (accept) state_nxt = empty_grid ? DONE : DISPATCH;
            DISPATCH: if (adv && last_ofs) state_nxt = DRAIN;
            DRAIN:    if (all_idle) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // NOTE: every register here uses non-blocking assignment, so all of them
    // update together from the values they held before this clock edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= IDLE;
            bofs_rdy    <= '0;
            o_done_dval <= 1'b0;
            o_bofs      <= '0;
            o_blk_cnt   <= '0;
            credit      <= '0;
            rr          <= '0;
            sel         <= '0;
            step_q      <= '0;
            end_q       <= '0;
        end else begin
            state       <= state_nxt;
            bofs_rdy    <= rdy_nxt;
            sel         <= sel_nxt;
            credit      <= credit_nxt;
            o_done_dval <= (state_nxt == DONE);
            if (accept) begin
                step_q    <= i_bgrid_step;
                end_q     <= i_bgrid_end;
                o_bofs    <= '0;
                o_blk_cnt <= '0;
            end else if (adv) begin
                o_bofs    <= ofs_nxt;
                o_blk_cnt <= o_blk_cnt + CNT_BW'(1);
                rr        <= rr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_multi_block_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_multi_block_dispatcher
//
// Directed bench for multi_block_dispatcher (N_CORE=2, VDIM=2, WBW=8,
// MAX_OUT=2). Each scenario task drives its stimulus and compares the DUT's
// outputs with hand-computed values. Inputs are driven and outputs sampled
// 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_multi_block_dispatcher;

    logic             i_clk;
    logic             i_rst;
    logic             src_rdy;
    logic             src_ack;
    logic [1:0][7:0]  i_bgrid_step;
    logic [1:0][7:0]  i_bgrid_end;
    logic [1:0]       bofs_rdy;
    logic [1:0]       bofs_ack;
    logic [1:0][7:0]  o_bofs;
    logic [1:0]       blkdone_dval;
    logic             o_done_dval;
    logic [15:0]      o_blk_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Log of offers seen by run_job.
    int         n_ack, n_done, n_multi;
    int         log_core [16];
    logic [7:0] log_o0   [16];
    logic [7:0] log_o1   [16];

    multi_block_dispatcher #(
        .N_CORE (2),
        .VDIM   (2),
        .WBW    (8),
        .MAX_OUT(2),
        .CNT_BW (16)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .src_rdy     (src_rdy),
        .src_ack     (src_ack),
        .i_bgrid_step(i_bgrid_step),
        .i_bgrid_end (i_bgrid_end),
        .bofs_rdy    (bofs_rdy),
        .bofs_ack    (bofs_ack),
        .o_bofs      (o_bofs),
        .blkdone_dval(blkdone_dval),
        .o_done_dval (o_done_dval),
        .o_blk_cnt   (o_blk_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst        = 1'b0;
        src_rdy      = 1'b0;
        bofs_ack     = '0;
        blkdone_dval = '0;
        repeat (2) tick();
        i_rst = 1'b1;
    endtask

    task automatic start_job(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] e0, input logic [7:0] e1);
        i_bgrid_step[0] = s0;
        i_bgrid_step[1] = s1;
        i_bgrid_end[0]  = e0;
        i_bgrid_end[1]  = e1;
        src_rdy = 1'b1;
        tick();
        src_rdy = 1'b0;
    endtask

    // Acts as the cores for ncyc cycles: acks every offer immediately, and
    // cores in done_mask report the block finished on the following cycle.
    task automatic run_job(input logic [1:0] done_mask, input int ncyc);
        logic [1:0] pending;
        pending = '0;
        n_ack   = 0;
        n_done  = 0;
        n_multi = 0;
        for (int i = 0; i < 16; i++) begin
            log_core[i] = -1;
            log_o0[i]   = '1;
            log_o1[i]   = '1;
        end
        for (int c = 0; c < ncyc; c++) begin
            tick();
            bofs_ack     = '0;
            blkdone_dval = pending;
            pending      = '0;
            if (o_done_dval) n_done++;
            if (bofs_rdy != '0) begin
                if ($countones(bofs_rdy) != 1) n_multi++;
                if (n_ack < 16) begin
                    log_core[n_ack] = bofs_rdy[1] ? 1 : 0;
                    log_o0[n_ack]   = o_bofs[0];
                    log_o1[n_ack]   = o_bofs[1];
                end
                n_ack++;
                bofs_ack = bofs_rdy;
                pending  = bofs_rdy & done_mask;
            end
        end
        bofs_ack     = '0;
        blkdone_dval = '0;
    endtask

    task automatic test_reset();
        i_rst           = 1'b0;
        src_rdy         = 1'b1;
        bofs_ack        = '0;
        blkdone_dval    = '0;
        i_bgrid_step    = '0;
        i_bgrid_end     = '0;
        repeat (2) tick();
        n_checks++;
        if (bofs_rdy !== 2'b00) begin n_fail++; $display("FAIL reset_rdy: got %b want 00", bofs_rdy); end
        n_checks++;
        if (o_done_dval !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", o_done_dval); end
        n_checks++;
        if (o_bofs !== 16'h0000) begin n_fail++; $display("FAIL reset_bofs: got %h want 0000", o_bofs); end
        n_checks++;
        if (o_blk_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", o_blk_cnt); end
        n_checks++;
        if (src_ack !== 1'b1) begin n_fail++; $display("FAIL reset_src_ack: got %b want 1", src_ack); end
        src_rdy = 1'b0;
        i_rst   = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int         exp_core [4] = '{0, 1, 0, 1};
        logic [7:0] exp_o0   [4] = '{8'd0, 8'd0, 8'd1, 8'd1};
        logic [7:0] exp_o1   [4] = '{8'd0, 8'd2, 8'd0, 8'd2};
        start_job(8'd1, 8'd2, 8'd2, 8'd4);
        // Changing the inputs mid-job must not affect the latched grid.
        i_bgrid_step[0] = 8'd3;
        i_bgrid_step[1] = 8'd3;
        i_bgrid_end[0]  = 8'd0;
        i_bgrid_end[1]  = 8'd1;
        run_job(2'b11, 20);
        n_checks++;
        if (n_ack !== 4) begin n_fail++; $display("FAIL basic_nblk: got %0d want 4", n_ack); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (log_core[i] !== exp_core[i] || log_o0[i] !== exp_o0[i] || log_o1[i] !== exp_o1[i]) begin
                n_fail++;
                $display("FAIL basic_blk%0d: got core %0d (%0d,%0d) want core %0d (%0d,%0d)",
                         i, log_core[i], log_o0[i], log_o1[i], exp_core[i], exp_o0[i], exp_o1[i]);
            end
        end
        n_checks++;
        if (n_multi !== 0) begin n_fail++; $display("FAIL basic_onehot: got %0d multi-rdy cycles want 0", n_multi); end
        n_checks++;
        if (n_done !== 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses want 1", n_done); end
        n_checks++;
        if (o_blk_cnt !== 16'd4) begin n_fail++; $display("FAIL basic_cnt: got %0d want 4", o_blk_cnt); end
    endtask

    task automatic test_empty_grid();
        start_job(8'd1, 8'd2, 8'd0, 8'd4);
        n_checks++;
        if (o_done_dval !== 1'b1) begin n_fail++; $display("FAIL empty_done: got %b want 1", o_done_dval); end
        n_checks++;
        if (o_blk_cnt !== 16'd0) begin n_fail++; $display("FAIL empty_cnt: got %0d want 0", o_blk_cnt); end
        n_checks++;
        if (bofs_rdy !== 2'b00) begin n_fail++; $display("FAIL empty_rdy: got %b want 00", bofs_rdy); end
        run_job(2'b11, 5);
        n_checks++;
        if (n_ack !== 0 || n_done !== 0) begin
            n_fail++;
            $display("FAIL empty_after: got %0d offers %0d dones want 0 0", n_ack, n_done);
        end
    endtask

    task automatic test_credit_limit();
        int exp_core [6] = '{0, 1, 0, 1, 0, 0};
        int c0, c1;
        c0 = 0;
        c1 = 0;
        start_job(8'd1, 8'd1, 8'd2, 8'd3);
        run_job(2'b01, 30);
        n_checks++;
        if (n_ack !== 6) begin n_fail++; $display("FAIL limit_nblk: got %0d want 6", n_ack); end
        for (int i = 0; i < 6; i++) begin
            if (log_core[i] == 0) c0++;
            if (log_core[i] == 1) c1++;
            n_checks++;
            if (log_core[i] !== exp_core[i]) begin
                n_fail++;
                $display("FAIL limit_core%0d: got %0d want %0d", i, log_core[i], exp_core[i]);
            end
        end
        n_checks++;
        if (c0 !== 4 || c1 !== 2) begin n_fail++; $display("FAIL limit_split: got %0d/%0d want 4/2", c0, c1); end
        n_checks++;
        if (n_done !== 0) begin n_fail++; $display("FAIL limit_early_done: got %0d want 0", n_done); end
        // Still draining: a new job must not be acknowledged.
        src_rdy = 1'b1;
        #1;
        n_checks++;
        if (src_ack !== 1'b0) begin n_fail++; $display("FAIL limit_busy_ack: got %b want 0", src_ack); end
        src_rdy      = 1'b0;
        blkdone_dval = 2'b10;
        tick();
        blkdone_dval = 2'b00;
        n_checks++;
        if (o_done_dval !== 1'b0) begin n_fail++; $display("FAIL limit_drain1: got %b want 0", o_done_dval); end
        tick();
        n_checks++;
        if (o_done_dval !== 1'b0) begin n_fail++; $display("FAIL limit_drain2: got %b want 0", o_done_dval); end
        blkdone_dval = 2'b10;
        tick();
        blkdone_dval = 2'b00;
        n_checks++;
        if (o_done_dval !== 1'b1) begin n_fail++; $display("FAIL limit_done: got %b want 1", o_done_dval); end
        n_checks++;
        if (o_blk_cnt !== 16'd6) begin n_fail++; $display("FAIL limit_cnt: got %0d want 6", o_blk_cnt); end
        tick();
        n_checks++;
        if (o_done_dval !== 1'b0) begin n_fail++; $display("FAIL limit_done_len: got %b want 0", o_done_dval); end
    endtask

    task automatic test_stall_and_same_cycle();
        start_job(8'd1, 8'd1, 8'd3, 8'd3);
        run_job(2'b00, 20);
        n_checks++;
        if (n_ack !== 4 || bofs_rdy !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_full: got %0d offers rdy %b want 4 offers rdy 00", n_ack, bofs_rdy);
        end
        blkdone_dval = 2'b10;
        tick();
        blkdone_dval = 2'b00;
        n_checks++;
        if (bofs_rdy !== 2'b10 || o_bofs[0] !== 8'd1 || o_bofs[1] !== 8'd1) begin
            n_fail++;
            $display("FAIL stall_reopen: got rdy %b (%0d,%0d) want 10 (1,1)", bofs_rdy, o_bofs[0], o_bofs[1]);
        end
        bofs_ack = 2'b10;
        tick();
        bofs_ack = 2'b00;
        n_checks++;
        if (bofs_rdy !== 2'b00) begin n_fail++; $display("FAIL stall_refull: got %b want 00", bofs_rdy); end
        // Bring core0 to credit 1, then ack and done on core0 together.
        blkdone_dval = 2'b01;
        tick();
        blkdone_dval = 2'b00;
        n_checks++;
        if (bofs_rdy !== 2'b01 || o_bofs[0] !== 8'd1 || o_bofs[1] !== 8'd2) begin
            n_fail++;
            $display("FAIL same_pre: got rdy %b (%0d,%0d) want 01 (1,2)", bofs_rdy, o_bofs[0], o_bofs[1]);
        end
        bofs_ack     = 2'b01;
        blkdone_dval = 2'b01;
        tick();
        bofs_ack     = 2'b00;
        blkdone_dval = 2'b00;
        tick();
        n_checks++;
        if (bofs_rdy !== 2'b01 || o_bofs[0] !== 8'd2 || o_bofs[1] !== 8'd0) begin
            n_fail++;
            $display("FAIL same_cycle: got rdy %b (%0d,%0d) want 01 (2,0)", bofs_rdy, o_bofs[0], o_bofs[1]);
        end
        bofs_ack = 2'b01;
        tick();
        bofs_ack = 2'b00;
        repeat (3) tick();
        n_checks++;
        if (bofs_rdy !== 2'b00) begin n_fail++; $display("FAIL same_full: got %b want 00", bofs_rdy); end
        do_reset();
    endtask

    task automatic test_reset_mid_job();
        int seen;
        start_job(8'd1, 8'd2, 8'd2, 8'd4);
        seen = 0;
        for (int c = 0; c < 5 && seen == 0; c++) begin
            if (bofs_rdy != '0) seen = 1; else tick();
        end
        bofs_ack = bofs_rdy;
        tick();
        bofs_ack = 2'b00;
        seen = 0;
        for (int c = 0; c < 5 && seen == 0; c++) begin
            if (bofs_rdy != '0) seen = 1; else tick();
        end
        n_checks++;
        if (bofs_rdy !== 2'b10) begin n_fail++; $display("FAIL abort_setup: got %b want 10", bofs_rdy); end
        #2;
        i_rst = 1'b0;
        #1;
        n_checks++;
        if (bofs_rdy !== 2'b00) begin n_fail++; $display("FAIL abort_rdy: got %b want 00", bofs_rdy); end
        @(posedge i_clk);
        #1;
        n_checks++;
        if (o_done_dval !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", o_done_dval); end
        i_rst   = 1'b1;
        src_rdy = 1'b1;
        #1;
        n_checks++;
        if (src_ack !== 1'b1) begin n_fail++; $display("FAIL abort_src_ack: got %b want 1", src_ack); end
        @(posedge i_clk);
        #1;
        src_rdy = 1'b0;
        run_job(2'b11, 20);
        n_checks++;
        if (log_core[0] !== 0 || log_o0[0] !== 8'd0 || log_o1[0] !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_restart: got core %0d (%0d,%0d) want core 0 (0,0)", log_core[0], log_o0[0], log_o1[0]);
        end
        n_checks++;
        if (n_ack !== 4 || n_done !== 1) begin
            n_fail++;
            $display("FAIL abort_rejob: got %0d offers %0d dones want 4 1", n_ack, n_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_grid();
        test_credit_limit();
        test_stall_and_same_cycle();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
